// File: rtl/ir_pkg.sv
// -----------------------------------------------------------------------------
// ir_pkg
//   Shared types and constants for the IR sampling sequencer.
//   - state_t : sequencer states
//   - CH_*    : A2D channel number for each named IR reading. The sequencer
//               walks the channels in numeric order, so this table also sets
//               the sampling order: R0,L0,R1,L1,R2,L2,R3,L3.
//   - max3    : helper used to size the shared cycle counter.
// -----------------------------------------------------------------------------
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CONV   = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int RES_W  = 12;
  localparam int NUM_CH = 8;

  localparam logic [2:0] CH_R0 = 3'd0;
  localparam logic [2:0] CH_L0 = 3'd1;
  localparam logic [2:0] CH_R1 = 3'd2;
  localparam logic [2:0] CH_L1 = 3'd3;
  localparam logic [2:0] CH_R2 = 3'd4;
  localparam logic [2:0] CH_L2 = 3'd5;
  localparam logic [2:0] CH_R3 = 3'd6;
  localparam logic [2:0] CH_L3 = 3'd7;

  // Last channel of a round; reaching it ends the round.
  localparam logic [2:0] CH_LAST = CH_L3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/ir_sample_regs.sv
// -----------------------------------------------------------------------------
// ir_sample_regs
//   Capture bank for the eight IR readings. One entry is written per cycle
//   when wr is high; entries hold their value otherwise. Reset clears all
//   readings to zero.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   wr                write strobe
//   widx[2:0]         entry to write (A2D channel number)
//   wdata[DATA_W-1:0] value to capture
//   IR_R0..IR_R3      right readings, inside out
//   IR_L0..IR_L3      left readings, inside out
// -----------------------------------------------------------------------------
module ir_sample_regs
  import ir_pkg::*;
#(
  parameter int DATA_W = RES_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [2:0]        widx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] IR_R0,
  output logic [DATA_W-1:0] IR_R1,
  output logic [DATA_W-1:0] IR_R2,
  output logic [DATA_W-1:0] IR_R3,
  output logic [DATA_W-1:0] IR_L0,
  output logic [DATA_W-1:0] IR_L1,
  output logic [DATA_W-1:0] IR_L2,
  output logic [DATA_W-1:0] IR_L3
);

  logic [DATA_W-1:0] bank [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        bank[i] <= '0;
      end
    end else if (wr) begin
      bank[widx] <= wdata;
    end
  end

  // Channel numbers map straight onto reading names through the package table.
  assign IR_R0 = bank[CH_R0];
  assign IR_L0 = bank[CH_L0];
  assign IR_R1 = bank[CH_R1];
  assign IR_L1 = bank[CH_L1];
  assign IR_R2 = bank[CH_R2];
  assign IR_L2 = bank[CH_L2];
  assign IR_R3 = bank[CH_R3];
  assign IR_L3 = bank[CH_L3];

endmodule

// File: rtl/ir_sample_seq.sv
// -----------------------------------------------------------------------------
// ir_sample_seq
//   Sequencer for the IR line sensors. After PERIOD idle cycles (and with en
//   high) it turns the IR emitters on, waits SETTLE_CYC cycles for the
//   receivers to settle, then converts the eight IR channels one after another
//   through the A2D, capturing each result. IR_vld pulses once per finished
//   round and the emitters are switched off again.
//   A channel whose conversion does not complete within TIMEOUT cycles is
//   abandoned: its reading keeps its previous value and cnv_timeout pulses.
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           sequencing enable, only looked at when a round is due
//   cnv_cmplt    A2D conversion done (1-cycle pulse), res valid with it
//   res[11:0]    A2D result
//   strt_cnv     start A2D conversion (1-cycle pulse)
//   chnnl[2:0]   A2D channel select
//   IR_en        IR emitter enable (registered)
//   IR_R0..R3    right readings, inside out
//   IR_L0..L3    left readings, inside out
//   IR_vld       round complete (1-cycle pulse)
//   cnv_timeout  channel abandoned (1-cycle pulse)
// -----------------------------------------------------------------------------
module ir_sample_seq
  import ir_pkg::*;
#(
  parameter int PERIOD     = 262144,
  parameter int SETTLE_CYC = 4096,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cnv_cmplt,
  input  logic [RES_W-1:0] res,
  output logic             strt_cnv,
  output logic [2:0]       chnnl,
  output logic             IR_en,
  output logic [RES_W-1:0] IR_R0,
  output logic [RES_W-1:0] IR_R1,
  output logic [RES_W-1:0] IR_R2,
  output logic [RES_W-1:0] IR_R3,
  output logic [RES_W-1:0] IR_L0,
  output logic [RES_W-1:0] IR_L1,
  output logic [RES_W-1:0] IR_L2,
  output logic [RES_W-1:0] IR_L3,
  output logic             IR_vld,
  output logic             cnv_timeout
);

  // One counter serves all three timed states, so it is sized for the longest.
  localparam int CNT_MAX = max3(PERIOD, SETTLE_CYC, TIMEOUT);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LAST_P = CW'(PERIOD - 1);
  localparam logic [CW-1:0] LAST_S = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] LAST_T = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;

  logic cnt_hold;
  logic idx_clr;
  logic idx_inc;
  logic ir_en_set;
  logic ir_en_clr;
  logic wr;
  logic adv;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next-state and control decode
  always_comb begin
    nxt         = state;
    strt_cnv    = 1'b0;
    IR_vld      = 1'b0;
    cnv_timeout = 1'b0;
    wr          = 1'b0;
    adv         = 1'b0;
    cnt_hold    = 1'b0;
    idx_clr     = 1'b0;
    idx_inc     = 1'b0;
    ir_en_set   = 1'b0;
    ir_en_clr   = 1'b0;

    case (state)
      IDLE: begin
        if (cnt == LAST_P) begin
          if (en) begin
            nxt       = SETTLE;
            ir_en_set = 1'b1;
            idx_clr   = 1'b1;
          end else begin
            // Round is due but disabled: park here so it starts the
            // cycle after en returns.
            cnt_hold = 1'b1;
          end
        end
      end

      SETTLE: begin
        if (cnt == LAST_S) begin
          nxt = CONV;
        end
      end

      CONV: begin
        strt_cnv = 1'b1;
        nxt      = WAIT;
      end

      WAIT: begin
        // A completion on the last allowed cycle still counts as a capture.
        if (cnv_cmplt) begin
          wr  = 1'b1;
          adv = 1'b1;
        end else if (cnt == LAST_T) begin
          cnv_timeout = 1'b1;
          adv         = 1'b1;
        end
        if (adv) begin
          if (idx == CH_LAST) begin
            nxt = DONE;
          end else begin
            idx_inc = 1'b1;
            nxt     = CONV;
          end
        end
      end

      DONE: begin
        IR_vld    = 1'b1;
        ir_en_clr = 1'b1;
        nxt       = IDLE;
      end

      default: begin
        nxt = IDLE;
      end
    endcase
  end

  // Shared cycle counter, restarted on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (nxt != state) begin
      cnt <= '0;
    end else if (!cnt_hold) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Channel index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (idx_clr) begin
      idx <= '0;
    end else if (idx_inc) begin
      idx <= idx + 3'd1;
    end
  end

  // Emitter enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IR_en <= 1'b0;
    end else if (ir_en_set) begin
      IR_en <= 1'b1;
    end else if (ir_en_clr) begin
      IR_en <= 1'b0;
    end
  end

  // idx only moves when a channel finishes, so chnnl stays stable from
  // strt_cnv through the end of that channel's wait.
  assign chnnl = idx;

  ir_sample_regs #(
    .DATA_W (RES_W)
  ) u_regs (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (wr),
    .widx  (idx),
    .wdata (res),
    .IR_R0 (IR_R0),
    .IR_R1 (IR_R1),
    .IR_R2 (IR_R2),
    .IR_R3 (IR_R3),
    .IR_L0 (IR_L0),
    .IR_L1 (IR_L1),
    .IR_L2 (IR_L2),
    .IR_L3 (IR_L3)
  );

endmodule

// File: tb/tb_ir_sample_seq.sv
// -----------------------------------------------------------------------------
// tb_ir_sample_seq
//   Bench for ir_sample_seq with PERIOD=64, SETTLE_CYC=8, TIMEOUT=16.
//   Cycle numbering: cycle 1 is the cycle right after reset release; cycle k
//   is entered by the (k-1)th rising edge. Inputs change on the falling edge,
//   outputs are sampled 1 time unit later.
//   The A2D responder answers each strt_cnv after a per-channel delay
//   (0 = never answers). Expected schedules and readings come from the
//   sequencing rules: first strt_cnv SETTLE_CYC cycles after IR_en rises,
//   each channel ends at strt+delay (answered) or strt+TIMEOUT (abandoned),
//   the next strt_cnv follows one cycle later, IR_vld one cycle after the last.
// -----------------------------------------------------------------------------
module tb_ir_sample_seq;

  localparam int PERIOD     = 64;
  localparam int SETTLE_CYC = 8;
  localparam int TIMEOUT    = 16;
  localparam int BUDGET     = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] res = 12'h000;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        IR_en;
  logic [11:0] IR_R0, IR_R1, IR_R2, IR_R3;
  logic [11:0] IR_L0, IR_L1, IR_L2, IR_L3;
  logic        IR_vld;
  logic        cnv_timeout;

  always #5 clk = ~clk;

  ir_sample_seq #(
    .PERIOD     (PERIOD),
    .SETTLE_CYC (SETTLE_CYC),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .cnv_cmplt   (cnv_cmplt),
    .res         (res),
    .strt_cnv    (strt_cnv),
    .chnnl       (chnnl),
    .IR_en       (IR_en),
    .IR_R0       (IR_R0),
    .IR_R1       (IR_R1),
    .IR_R2       (IR_R2),
    .IR_R3       (IR_R3),
    .IR_L0       (IR_L0),
    .IR_L1       (IR_L1),
    .IR_L2       (IR_L2),
    .IR_L3       (IR_L3),
    .IR_vld      (IR_vld),
    .cnv_timeout (cnv_timeout)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // A2D model configuration and reference readings
  int          delay   [8];
  logic [11:0] res_tab [8];
  logic [11:0] exp_rd  [8];
  bit          pend = 1'b0;
  int          cd = 0;
  logic [2:0]  pend_ch = 3'd0;
  bit          spur = 1'b0;
  logic [11:0] spur_val = 12'h000;

  // Observed events
  int         strt_c[$];
  logic [2:0] strt_ch_q[$];
  int         to_c[$];
  int         vld_c[$];
  int         en_rise = -1;
  int         en_fall = -1;
  bit         en_prev = 1'b0;

  // Expected schedule
  int exp_strt[$];
  int exp_to[$];
  int exp_vld = 0;
  int last_vld = 0;

  function automatic logic [11:0] obs_rd(input int i);
    case (i)
      0: return IR_R0;
      1: return IR_L0;
      2: return IR_R1;
      3: return IR_L1;
      4: return IR_R2;
      5: return IR_L2;
      6: return IR_R3;
      7: return IR_L3;
      default: return 12'h000;
    endcase
  endfunction

  task automatic clear_rec();
    strt_c.delete();
    strt_ch_q.delete();
    to_c.delete();
    vld_c.delete();
    en_rise = -1;
    en_fall = -1;
  endtask

  // Advance one cycle: drive A2D response on the falling edge, then sample.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    cnv_cmplt = 1'b0;
    if (spur) begin
      cnv_cmplt = 1'b1;
      res       = spur_val;
      spur      = 1'b0;
    end else if (pend) begin
      cd--;
      if (cd == 0) begin
        cnv_cmplt       = 1'b1;
        res             = res_tab[pend_ch];
        exp_rd[pend_ch] = res_tab[pend_ch];
        pend            = 1'b0;
      end
    end
    #1;
    if (strt_cnv) begin
      strt_c.push_back(cyc);
      strt_ch_q.push_back(chnnl);
      if (delay[chnnl] != 0) begin
        pend    = 1'b1;
        cd      = delay[chnnl];
        pend_ch = chnnl;
      end
    end
    if (cnv_timeout) to_c.push_back(cyc);
    if (IR_vld) vld_c.push_back(cyc);
    if (IR_en && !en_prev) en_rise = cyc;
    if (!IR_en && en_prev) en_fall = cyc;
    en_prev = IR_en;
  endtask

  task automatic run_until_vld(input int budget);
    int n;
    n = 0;
    while (vld_c.size() == 0 && n < budget) begin
      cycle();
      n++;
    end
    repeat (2) cycle();
  endtask

  // Reference schedule for a round whose IR_en rises in cycle e.
  task automatic build_expect(input int e);
    int t;
    int ev;
    exp_strt.delete();
    exp_to.delete();
    t = e + SETTLE_CYC;
    for (int ch = 0; ch < 8; ch++) begin
      exp_strt.push_back(t);
      if (delay[ch] != 0 && delay[ch] <= TIMEOUT) begin
        ev = t + delay[ch];
      end else begin
        ev = t + TIMEOUT;
        exp_to.push_back(ev);
      end
      t = ev + 1;
    end
    exp_vld = t;
  endtask

  task automatic test_reset();
    en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({strt_cnv, IR_en, IR_vld, cnv_timeout, chnnl} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, want 0000000", {strt_cnv, IR_en, IR_vld, cnv_timeout, chnnl});
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_rd(i) !== 12'h000) begin
        errors++;
        $display("FAIL reset_rd%0d: got %h, want 000", i, obs_rd(i));
      end
      exp_rd[i] = 12'h000;
    end
    @(negedge clk);
    rst_n   = 1'b1;
    cyc     = 1;
    en_prev = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) begin
      delay[i]   = 3;
      res_tab[i] = 12'(256 + i);
    end
    clear_rec();
    run_until_vld(BUDGET);
    checks++;
    if (en_rise !== 65) begin
      errors++;
      $display("FAIL basic_en_rise: got cycle %0d, want 65", en_rise);
    end
    build_expect(en_rise);
    checks++;
    if (strt_c.size() !== 8) begin
      errors++;
      $display("FAIL basic_strt_count: got %0d, want 8", strt_c.size());
    end
    for (int i = 0; i < strt_c.size() && i < 8; i++) begin
      checks++;
      if (strt_ch_q[i] !== 3'(i) || strt_c[i] !== exp_strt[i]) begin
        errors++;
        $display("FAIL basic_strt%0d: got ch %0d @%0d, want ch %0d @%0d", i, strt_ch_q[i], strt_c[i], i, exp_strt[i]);
      end
    end
    checks++;
    if (to_c.size() !== 0) begin
      errors++;
      $display("FAIL basic_timeouts: got %0d, want 0", to_c.size());
    end
    checks++;
    if (vld_c.size() !== 1 || (vld_c.size() == 1 && vld_c[0] !== exp_vld)) begin
      errors++;
      $display("FAIL basic_vld: got %0d pulses first @%0d, want 1 @%0d", vld_c.size(), (vld_c.size() > 0) ? vld_c[0] : -1, exp_vld);
    end
    checks++;
    if (en_fall !== exp_vld + 1) begin
      errors++;
      $display("FAIL basic_en_fall: got %0d, want %0d", en_fall, exp_vld + 1);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_rd(i) !== 12'(256 + i)) begin
        errors++;
        $display("FAIL basic_rd%0d: got %h, want %h", i, obs_rd(i), 12'(256 + i));
      end
    end
    if (vld_c.size() > 0) last_vld = vld_c[0];
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 8; i++) res_tab[i] = 12'(512 + i);
    delay[3] = 0;
    clear_rec();
    run_until_vld(BUDGET);
    checks++;
    if (en_rise !== last_vld + PERIOD + 1) begin
      errors++;
      $display("FAIL to_en_rise: got %0d, want %0d", en_rise, last_vld + PERIOD + 1);
    end
    build_expect(en_rise);
    checks++;
    if (to_c.size() !== 1 || strt_c.size() !== 8) begin
      errors++;
      $display("FAIL to_count: got %0d timeouts %0d starts, want 1 and 8", to_c.size(), strt_c.size());
    end else begin
      checks++;
      if (to_c[0] !== strt_c[3] + 16 || to_c[0] !== exp_to[0]) begin
        errors++;
        $display("FAIL to_cycle: got %0d, want %0d", to_c[0], strt_c[3] + 16);
      end
    end
    checks++;
    if (vld_c.size() !== 1 || (vld_c.size() == 1 && vld_c[0] !== exp_vld)) begin
      errors++;
      $display("FAIL to_vld: got %0d pulses, want 1 @%0d", vld_c.size(), exp_vld);
    end
    checks++;
    if (IR_L1 !== 12'h103) begin
      errors++;
      $display("FAIL to_L1_kept: got %h, want 103", IR_L1);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_rd(i) !== exp_rd[i]) begin
        errors++;
        $display("FAIL to_rd%0d: got %h, want %h", i, obs_rd(i), exp_rd[i]);
      end
    end
    if (vld_c.size() > 0) last_vld = vld_c[0];
  endtask

  task automatic test_exact_timeout();
    for (int i = 0; i < 8; i++) begin
      res_tab[i] = 12'(768 + i);
      delay[i]   = 3;
    end
    delay[5] = TIMEOUT;
    clear_rec();
    run_until_vld(BUDGET);
    build_expect(en_rise);
    checks++;
    if (to_c.size() !== 0) begin
      errors++;
      $display("FAIL exact_no_timeout: got %0d pulses, want 0", to_c.size());
    end
    checks++;
    if (IR_L2 !== 12'h305) begin
      errors++;
      $display("FAIL exact_L2: got %h, want 305", IR_L2);
    end
    checks++;
    if (vld_c.size() !== 1 || (vld_c.size() == 1 && vld_c[0] !== exp_vld)) begin
      errors++;
      $display("FAIL exact_vld: got %0d pulses, want 1 @%0d", vld_c.size(), exp_vld);
    end
    if (vld_c.size() > 0) last_vld = vld_c[0];
  endtask

  task automatic test_en_gating();
    int x;
    int n;
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      res_tab[i] = 12'(1024 + i);
      delay[i]   = 3;
    end
    clear_rec();
    while (cyc < last_vld + PERIOD + 10) cycle();
    checks++;
    if (en_rise !== -1 || strt_c.size() !== 0) begin
      errors++;
      $display("FAIL gate_hold: got IR_en rise %0d starts %0d, want none", en_rise, strt_c.size());
    end
    en = 1'b1;
    x  = cyc;
    n  = 0;
    while (vld_c.size() == 0 && n < BUDGET) begin
      cycle();
      n++;
      if (strt_c.size() >= 2) en = 1'b0;
    end
    repeat (2) cycle();
    checks++;
    if (en_rise !== x + 1) begin
      errors++;
      $display("FAIL gate_start: got %0d, want %0d", en_rise, x + 1);
    end
    checks++;
    if (vld_c.size() !== 1 || strt_c.size() !== 8) begin
      errors++;
      $display("FAIL gate_complete: got %0d vld %0d starts, want 1 and 8", vld_c.size(), strt_c.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_rd(i) !== exp_rd[i]) begin
        errors++;
        $display("FAIL gate_rd%0d: got %h, want %h", i, obs_rd(i), exp_rd[i]);
      end
    end
    if (vld_c.size() > 0) last_vld = vld_c[0];
  endtask

  task automatic test_spurious();
    clear_rec();
    spur     = 1'b1;
    spur_val = 12'hABC;
    repeat (3) cycle();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_rd(i) !== exp_rd[i]) begin
        errors++;
        $display("FAIL spur_rd%0d: got %h, want %h", i, obs_rd(i), exp_rd[i]);
      end
    end
    checks++;
    if (strt_c.size() !== 0 || vld_c.size() !== 0) begin
      errors++;
      $display("FAIL spur_activity: got %0d starts %0d vld, want 0 and 0", strt_c.size(), vld_c.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      res_tab[i] = 12'(1280 + i);
      delay[i]   = 3;
    end
    clear_rec();
    n = 0;
    while (strt_ch_q.size() < 6 && n < BUDGET) begin
      cycle();
      n++;
    end
    cycle();
    checks++;
    if (strt_ch_q.size() !== 6 || (strt_ch_q.size() == 6 && strt_ch_q[5] !== 3'd5)) begin
      errors++;
      $display("FAIL rmid_reach_ch5: got %0d starts, want 6 ending on ch 5", strt_ch_q.size());
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({strt_cnv, IR_en, IR_vld, cnv_timeout, chnnl} !== 7'd0) begin
      errors++;
      $display("FAIL rmid_ctrl: got %b, want 0000000", {strt_cnv, IR_en, IR_vld, cnv_timeout, chnnl});
    end
    for (int i = 0; i < 8; i++) begin
      exp_rd[i] = 12'h000;
      checks++;
      if (obs_rd(i) !== 12'h000) begin
        errors++;
        $display("FAIL rmid_rd%0d: got %h, want 000", i, obs_rd(i));
      end
    end
    pend      = 1'b0;
    cnv_cmplt = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    cyc     = 1;
    en_prev = 1'b0;
    clear_rec();
    run_until_vld(BUDGET);
    checks++;
    if (en_rise !== PERIOD + 1) begin
      errors++;
      $display("FAIL rmid_restart: got %0d, want %0d", en_rise, PERIOD + 1);
    end
    checks++;
    if (vld_c.size() !== 1 || IR_L3 !== 12'h507) begin
      errors++;
      $display("FAIL rmid_round: got %0d vld L3=%h, want 1 and 507", vld_c.size(), IR_L3);
    end
    if (vld_c.size() > 0) last_vld = vld_c[0];
  endtask

  task automatic test_random();
    en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        delay[i]   = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
        res_tab[i] = 12'($urandom);
      end
      clear_rec();
      run_until_vld(BUDGET);
      checks++;
      if (en_rise !== last_vld + PERIOD + 1) begin
        errors++;
        $display("FAIL rnd%0d_en_rise: got %0d, want %0d", r, en_rise, last_vld + PERIOD + 1);
      end
      build_expect(en_rise);
      checks++;
      if (strt_c.size() !== 8 || to_c.size() !== exp_to.size()) begin
        errors++;
        $display("FAIL rnd%0d_counts: got %0d starts %0d timeouts, want 8 and %0d", r, strt_c.size(), to_c.size(), exp_to.size());
      end else begin
        for (int i = 0; i < 8; i++) begin
          checks++;
          if (strt_ch_q[i] !== 3'(i) || strt_c[i] !== exp_strt[i]) begin
            errors++;
            $display("FAIL rnd%0d_strt%0d: got ch %0d @%0d, want ch %0d @%0d", r, i, strt_ch_q[i], strt_c[i], i, exp_strt[i]);
          end
        end
        for (int i = 0; i < to_c.size(); i++) begin
          checks++;
          if (to_c[i] !== exp_to[i]) begin
            errors++;
            $display("FAIL rnd%0d_to%0d: got @%0d, want @%0d", r, i, to_c[i], exp_to[i]);
          end
        end
      end
      checks++;
      if (vld_c.size() !== 1 || (vld_c.size() == 1 && vld_c[0] !== exp_vld)) begin
        errors++;
        $display("FAIL rnd%0d_vld: got %0d pulses, want 1 @%0d", r, vld_c.size(), exp_vld);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs_rd(i) !== exp_rd[i]) begin
          errors++;
          $display("FAIL rnd%0d_rd%0d: got %h, want %h", r, i, obs_rd(i), exp_rd[i]);
        end
      end
      if (vld_c.size() > 0) last_vld = vld_c[0];
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_exact_timeout();
    test_en_gating();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
